// File: rtl/vga_pkg.sv
// vga_pkg: shared framebuffer geometry defaults, fill FSM state encoding and span check helper.
package vga_pkg;
    localparam int MEM_WIDTH_DEF  = 16;
    localparam int MEM_HEIGHT_DEF = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    // A span is usable when it is non-empty and ends inside the framebuffer.
    function automatic logic span_fits(input logic [4:0] start, input logic [4:0] len, input int limit);
        return len != 5'd0 && (int'(start) + int'(len)) <= limit;
    endfunction
endpackage

// File: rtl/vga_rect_cursor.sv
// vga_rect_cursor: raster-order col/row cursor over a latched rectangle.
//   Clock, Reset   : system clock, asynchronous active-low reset
//   load           : capture x/y/w/h and park the cursor at (x,y)
//   advance        : step to the next pixel in raster order
//   x, y, w, h     : rectangle origin and size
//   col, row, last : current cursor position, high on the bottom-right pixel
module vga_rect_cursor (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       load,
    input  logic       advance,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [4:0] w,
    input  logic [3:0] h,
    output logic [3:0] col,
    output logic [3:0] row,
    output logic       last
);
    logic [3:0] x_q, y_q, h_q;
    logic [4:0] w_q;
    logic [5:0] end_col, end_row;
    logic       at_end_col;

    assign end_col    = 6'(x_q) + 6'(w_q) - 6'd1;
    assign end_row    = 6'(y_q) + 6'(h_q) - 6'd1;
    assign at_end_col = 6'(col) == end_col;
    assign last       = at_end_col && 6'(row) == end_row;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            x_q <= '0;
            y_q <= '0;
            w_q <= '0;
            h_q <= '0;
            col <= '0;
            row <= '0;
        end else if (load) begin
            x_q <= x;
            y_q <= y;
            w_q <= w;
            h_q <= h;
            col <= x;
            row <= y;
        end else if (advance) begin
            col <= at_end_col ? x_q : col + 4'd1;
            row <= at_end_col ? row + 4'd1 : row;
        end
    end
endmodule

// File: rtl/vga_fill_arbiter.sv
// vga_fill_arbiter: merges CPU pixel writes with a rectangle-fill engine onto one registered video memory write port.
//   Clock, Reset                  : system clock, asynchronous active-low reset
//   iCpuWrite/iCpuAddr/iCpuData   : single-pixel CPU write, always wins the port
//   iFillStart + iFillX/Y/W/H/Color : one-cycle rectangle fill request, accepted only when idle
//   oWriteEnable/Address/Data     : registered write port (request in cycle k shows in k+1)
//   oBusy, oDone, oError          : fill in progress, fill complete pulse, rejected fill pulse
module vga_fill_arbiter #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_WIDTH  = vga_pkg::MEM_WIDTH_DEF,
    parameter int MEM_HEIGHT = vga_pkg::MEM_HEIGHT_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iCpuWrite,
    input  logic [ADDR_WIDTH-1:0] iCpuAddr,
    input  logic [DATA_WIDTH-1:0] iCpuData,
    input  logic                  iFillStart,
    input  logic [3:0]            iFillX,
    input  logic [3:0]            iFillY,
    input  logic [4:0]            iFillW,
    input  logic [3:0]            iFillH,
    input  logic [DATA_WIDTH-1:0] iFillColor,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0] oWriteData,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oError
);
    import vga_pkg::*;

    fill_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] color_q;
    logic [3:0]            col, row;
    logic                  last, start, valid, fill_wr;
    logic [ADDR_WIDTH-1:0] fill_addr;

    assign start     = state_q == IDLE && iFillStart;
    assign valid     = span_fits(5'(iFillX), iFillW, MEM_WIDTH) && span_fits(5'(iFillY), 5'(iFillH), MEM_HEIGHT);
    // A CPU write steals the slot; the cursor then holds so the pixel is retried next cycle.
    assign fill_wr   = state_q == FILL && !iCpuWrite;
    assign fill_addr = ADDR_WIDTH'(row) * ADDR_WIDTH'(MEM_WIDTH) + ADDR_WIDTH'(col);
    assign oBusy     = state_q != IDLE;
    assign oDone     = state_q == DONE;

    vga_rect_cursor u_cursor (
        .Clock   (Clock),
        .Reset   (Reset),
        .load    (start),
        .advance (fill_wr),
        .x       (iFillX),
        .y       (iFillY),
        .w       (iFillW),
        .h       (iFillH),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    always_comb begin
        state_d = state_q == IDLE ? (start && valid ? FILL : IDLE)
                : state_q == FILL ? (fill_wr && last ? DONE : FILL)
                : IDLE;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            color_q       <= '0;
            oWriteEnable  <= 1'b0;
            oWriteAddress <= '0;
            oWriteData    <= '0;
            oError        <= 1'b0;
        end else begin
            state_q       <= state_d;
            color_q       <= start ? iFillColor : color_q;
            oWriteEnable  <= iCpuWrite || fill_wr;
            oWriteAddress <= iCpuWrite ? iCpuAddr : fill_addr;
            oWriteData    <= iCpuWrite ? iCpuData : color_q;
            oError        <= start && !valid;
        end
    end
endmodule

// File: doc/vga_fill_arbiter.md
VGA_FILL_ARBITER -- requirements
Module: vga_fill_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 3, meaning bits per pixel colour.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning video memory write address width.
REQ-003 SHALL have parameter MEM_WIDTH, default 16, meaning pixels per framebuffer row.
REQ-004 SHALL have parameter MEM_HEIGHT, default 12, meaning framebuffer rows.
REQ-005 SHALL have one clock and asynchronous active-low reset: Clock  in  1  system clock; Reset  in  1  asynchronous reset, active-low.
REQ-006 SHALL have iCpuWrite  in  1  single-pixel write request from the CPU VGA instruction.
REQ-007 SHALL have iCpuAddr  in  ADDR_WIDTH  CPU write address.
REQ-008 SHALL have iCpuData  in  DATA_WIDTH  CPU pixel colour.
REQ-009 SHALL have iFillStart  in  1  one-cycle rectangle fill request.
REQ-010 SHALL have iFillX  in  4  left column; iFillY  in  4  top row.
REQ-011 SHALL have iFillW  in  5  width in pixels; iFillH  in  4  height in rows.
REQ-012 SHALL have iFillColor  in  DATA_WIDTH  fill colour.
REQ-013 SHALL have oWriteEnable  out  1, oWriteAddress  out  ADDR_WIDTH, oWriteData  out  DATA_WIDTH: video memory write port.
REQ-014 SHALL have oBusy  out  1  fill in progress; oDone  out  1  fill completed pulse; oError  out  1  rejected fill pulse.

Function
REQ-015 SHALL register the write port outputs: a request arbitrated in cycle k appears on the port in cycle k+1.
REQ-016 SHALL give iCpuWrite absolute priority; a CPU write is never dropped or delayed.
REQ-017 SHALL use the FSM states IDLE, FILL, DONE; oBusy = (state != IDLE); oDone = (state == DONE).
REQ-018 SHALL, in IDLE with iFillStart high, latch X, Y, W, H and colour, then validate them.
REQ-019 SHALL reject the fill when W==0, H==0, X+W>MEM_WIDTH or Y+H>MEM_HEIGHT: oError is high for exactly one cycle, and the FSM stays in IDLE.
REQ-020 SHALL, for a valid request, enter FILL with the cursor at (X,Y); the address is row*MEM_WIDTH+col, computed at ADDR_WIDTH width.
REQ-021 SHALL, in each FILL cycle without iCpuWrite, issue one fill write at the cursor and advance it in raster order: col+1; at col==X+W-1, col=X and row+1.
REQ-022 SHALL hold the cursor unchanged in any FILL cycle where iCpuWrite is high.
REQ-023 SHALL move FILL->DONE after the write at (X+W-1, Y+H-1), and move DONE->IDLE unconditionally after one cycle.
REQ-024 SHALL ignore iFillStart outside IDLE, including in DONE.
REQ-025 SHALL time an uncontended fill started in cycle n as follows: port writes in cycles n+2..n+W*H+1; oBusy high n+1..n+W*H+1; oDone high in cycle n+W*H+1.
REQ-026 SHALL extend completion by exactly one cycle per colliding CPU write.

Reset
REQ-027 SHALL, while Reset is low, force: state IDLE; oWriteEnable, oBusy, oDone and oError 0; oWriteAddress and oWriteData 0; cursor and latched parameters 0.
REQ-028 SHALL abort any fill in progress on a reset assertion; after release no residual write occurs, and a new iFillStart is required.

Structure
REQ-029 SHALL take MEM_WIDTH and MEM_HEIGHT defaults and the IDLE/FILL/DONE state encoding from the shared package vga_pkg.
REQ-030 SHALL implement the cursor (col/row counters, wrap and last-pixel detect) in one sub-module, vga_rect_cursor.

Verification
REQ-031 SHALL cover: CPU write addr 37 data 6 in cycle n -> oWriteEnable=1, addr 37, data 6 in cycle n+1 only.
REQ-032 SHALL cover: fill X=3 Y=4 W=2 H=2 colour 5 -> writes at addresses 67, 68, 83, 84 in consecutive cycles, each with data 5; oDone in the same cycle as the write to 84.
REQ-033 SHALL cover: the above fill with a CPU write (addr 10, data 1) on the first FILL cycle -> port order 10, 67, 68, 83, 84; oDone one cycle later than uncontended.
REQ-034 SHALL cover: fill X=15 W=2, and separately H=0 -> oError one cycle, no port writes, oBusy stays 0.
REQ-035 SHALL cover: full screen X=0 Y=0 W=16 H=12, with a second iFillStart mid-fill -> addresses 0..191 exactly once each, 192 writes, a single oDone.
REQ-036 SHALL cover: Reset low after the 5th write of a full-screen fill -> all outputs 0 immediately, no writes after release until a new start.
